reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  32-entry register file with a pending-write scoreboard. It sits directly
//  downstream of the 5-bit destination-address select. The selected rt/rd
//  address drives wr_addr / iss_dst here.
//  Provides two combinational read ports and one clocked write port. Raises
//  stall when an issuing instruction reads or overwrites a register whose
//  producer has not yet written back.
// PARAMETERS
//  DATA_W    32  register width in bits
//  NUM_REGS  32  number of architectural registers (reg 0 hardwired to zero)
//  ADDR_W     5  register address width; NUM_REGS == 2**ADDR_W
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       asynchronous, active-high reset
//  rs_addr   in   ADDR_W  read port A address
//  rt_addr   in   ADDR_W  read port B address
//  rs_data   out  DATA_W  read port A data (combinational)
//  rt_data   out  DATA_W  read port B data (combinational)
//  wr_en     in   1       writeback valid
//  wr_addr   in   ADDR_W  writeback destination (from dest-address select)
//  wr_data   in   DATA_W  writeback data
//  iss_valid in   1       instruction presented for issue this cycle
//  iss_wr    in   1       issuing instruction writes a register
//  iss_dst   in   ADDR_W  destination of issuing instruction
//  rs_used   in   1       issuing instruction reads rs
//  rt_used   in   1       issuing instruction reads rt
//  stall     out  1       issue refused this cycle (combinational)
//  pend_cnt  out  ADDR_W+1  number of registers currently pending (registered)
// BEHAVIOUR
//  - Reset (async): all registers = 0, pending[] = 0, pend_cnt = 0; stall = 0.
//  - Read: data = regs[addr]; addr 0 always returns 0.
//  - Write: on posedge, if wr_en && wr_addr != 0, regs[wr_addr] <= wr_data.
//    Writes to reg 0 are dropped. Without bypass, written data is visible next cycle.
//  - hz(a) = pending[a] && a != 0 (&& !(wr_en && wr_addr == a) when bypass built).
//  - stall = iss_valid && ((rs_used && hz(rs)) || (rt_used && hz(rt))
//            || (iss_wr && hz(iss_dst))). The last term is the WAW guard.
//  - accept = iss_valid && !stall.
//    On posedge: set pending[iss_dst] if accept && iss_wr && iss_dst != 0.
//  - On posedge: clear pending[wr_addr] if wr_en.
//    Same address set+clear in one cycle: set wins (new producer).
//  - pend_cnt is updated incrementally in the same cycle:
//    +1 per bit going 0->1, -1 per bit going 1->0.
//    Set+clear on the same bit nets 0.
//    Clear of a non-pending bit leaves pend_cnt unchanged.
//  - Latency: read 0 cycles; write to read-visible 1 cycle (0 with bypass).
//    Scoreboard set/clear 1 cycle.
//  - Reset asserted mid-operation discards all pending state; no partial write.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - Read ports forward wr_data when wr_en && wr_addr == rs/rt_addr && addr != 0.
//    - A register being written this cycle is not a hazard.
//  REGFILE_BYPASS_EN undefined:
//    - No forwarding; hazard persists until the cycle after the writeback.
// STRUCTURE
//  - Package regfile_pkg: DATA_W, ADDR_W and NUM_REGS constants;
//    reg_addr_t and reg_data_t typedefs.
//  - Sub-module rf_scoreboard: pending[] bits, pend_cnt, hz()/stall logic.
//  - The top level holds the storage array, read/bypass muxing and write port.
// TESTING
//  - Reset sequence: all reads return 0, pend_cnt = 0, stall = 0.
//  - Write 0xDEADBEEF to r5:
//    - Without bypass: rs_addr=5 reads 0 in the write cycle, 0xDEADBEEF next cycle.
//  - Write 0x1234 to r0: rs_addr=0 reads 0 afterwards; pend_cnt stays 0.
//  - RAW hazard:
//    - Issue iss_dst=8 -> pend_cnt=1.
//    - Next issue with rs=8, rs_used=1 -> stall=1 until writeback to r8.
//    - With bypass: stall=0 in the wr_en cycle and rs_data = wr_data.
//  - Same cycle: wr_en to r8 (pending) and accepted issue to r8 -> pending[8]=1, pend_cnt unchanged.
//  - Three registers pending, then assert reset mid-stream -> pend_cnt=0, stall=0, all regs 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int CNT_W    = ADDR_W + 1;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: per-register busy bits, count and issue stall.
// With REGFILE_BYPASS_EN a register written back this cycle is not a hazard.
module rf_scoreboard
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  reg_addr_t        wr_addr,
    input  logic             iss_valid,
    input  logic             iss_wr,
    input  reg_addr_t        iss_dst,
    input  reg_addr_t        rs_addr,
    input  reg_addr_t        rt_addr,
    input  logic             rs_used,
    input  logic             rt_used,
    output logic             stall,
    output logic [CNT_W-1:0] pend_cnt
);

    logic [NUM_REGS-1:0] pending;
    logic                accept;
    logic                set_en;
    logic                inc;
    logic                dec;

    function automatic logic hz(input reg_addr_t a);
        logic h;
        h = pending[a] && (a != '0);
`ifdef REGFILE_BYPASS_EN
        h = h && !(wr_en && (wr_addr == a));
`endif
        return h;
    endfunction

    assign stall = iss_valid &&
                   ((rs_used && hz(rs_addr)) ||
                    (rt_used && hz(rt_addr)) ||
                    (iss_wr  && hz(iss_dst)));

    assign accept = iss_valid && !stall;
    assign set_en = accept && iss_wr && (iss_dst != '0);

    // A same-address set and clear leaves the bit set, so no decrement.
    assign inc = set_en && !pending[iss_dst];
    assign dec = wr_en && pending[wr_addr] &&
                 !(set_en && (iss_dst == wr_addr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_en)
                pending[wr_addr] <= 1'b0;
            if (set_en)
                pending[iss_dst] <= 1'b1;
            pend_cnt <= pend_cnt + CNT_W'(inc) - CNT_W'(dec);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// 32-entry register file, two async read ports, one write port, scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (forward wr_data to reads).
module reg_file_sb
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  reg_addr_t        rs_addr,
    input  reg_addr_t        rt_addr,
    output reg_data_t        rs_data,
    output reg_data_t        rt_data,
    input  logic             wr_en,
    input  reg_addr_t        wr_addr,
    input  reg_data_t        wr_data,
    input  logic             iss_valid,
    input  logic             iss_wr,
    input  reg_addr_t        iss_dst,
    input  logic             rs_used,
    input  logic             rt_used,
    output logic             stall,
    output logic [CNT_W-1:0] pend_cnt
);

    reg_data_t regs [NUM_REGS];

    function automatic reg_data_t rd(input reg_addr_t a);
        reg_data_t d;
        d = regs[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == a))
            d = wr_data;
`endif
        if (a == '0)
            d = '0;
        return d;
    endfunction

    assign rs_data = rd(rs_addr);
    assign rt_data = rd(rt_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_wr    (iss_wr),
        .iss_dst   (iss_dst),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_used   (rs_used),
        .rt_used   (rt_used),
        .stall     (stall),
        .pend_cnt  (pend_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed cases plus randomized run vs. a model.
// Build with REGFILE_BYPASS_EN defined to exercise the forwarding variant.
module tb_reg_file_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        iss_valid = 1'b0;
    logic        iss_wr = 1'b0;
    logic [4:0]  iss_dst = '0;
    logic        rs_used = 1'b0;
    logic        rt_used = 1'b0;
    logic        stall;
    logic [5:0]  pend_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk       (clk),
        .reset     (reset),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_wr    (iss_wr),
        .iss_dst   (iss_dst),
        .rs_used   (rs_used),
        .rt_used   (rt_used),
        .stall     (stall),
        .pend_cnt  (pend_cnt)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic bit m_hz(input int a);
        if (a == 0 || !m_pend[a])
            return 1'b0;
        if (BYP && wr_en && int'(wr_addr) == a)
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0)
            return '0;
        if (BYP && wr_en && int'(wr_addr) == a)
            return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit m_stall();
        return iss_valid &&
               ((rs_used && m_hz(int'(rs_addr))) ||
                (rt_used && m_hz(int'(rt_addr))) ||
                (iss_wr && m_hz(int'(iss_dst))));
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++)
            n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic compare();
        chk("rs_data", rs_data, m_read(int'(rs_addr)));
        chk("rt_data", rt_data, m_read(int'(rt_addr)));
        chk("stall", 32'(stall), 32'(m_stall()));
        chk("pend_cnt", 32'(pend_cnt), 32'(m_cnt()));
    endtask

    // Check at negedge, then advance the model across the posedge.
    task automatic tick();
        bit          do_wr;
        bit          do_clr;
        bit          do_set;
        int          wa;
        int          da;
        logic [31:0] wd;
        @(negedge clk);
        compare();
        wa     = int'(wr_addr);
        da     = int'(iss_dst);
        wd     = wr_data;
        do_wr  = wr_en && wa != 0;
        do_clr = wr_en;
        do_set = iss_valid && !m_stall() && iss_wr && da != 0;
        @(posedge clk);
        if (do_wr)
            m_regs[wa] = wd;
        if (do_clr)
            m_pend[wa] = 1'b0;
        if (do_set)
            m_pend[da] = 1'b1;
        #1;
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        iss_valid = 1'b0;
        iss_wr    = 1'b0;
        rs_used   = 1'b0;
        rt_used   = 1'b0;
    endtask

    task automatic all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            chk(name, rs_data, 32'h0);
            chk(name, rt_data, 32'h0);
        end
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 3) == 0)
            return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        model_reset();
        #12;
        chk("rst_pend_cnt", 32'(pend_cnt), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        all_zero("rst_read");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Write r5, observe write-cycle and next-cycle read.
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hDEADBEEF;
        rs_addr = 5'd5;
        #1;
        chk("r5_wr_cycle", rs_data,
            BYP ? 32'hDEADBEEF : 32'h0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("r5_next", rs_data, 32'hDEADBEEF);
        tick();

        // Writes to r0 are dropped.
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'h1234;
        tick();
        wr_en   = 1'b0;
        rs_addr = 5'd0;
        #1;
        chk("r0_read", rs_data, 32'h0);
        chk("r0_cnt", 32'(pend_cnt), 32'd0);

        // RAW hazard on r8.
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        iss_dst   = 5'd8;
        tick();
        chk("raw_cnt1", 32'(pend_cnt), 32'd1);
        iss_wr  = 1'b0;
        rs_addr = 5'd8;
        rs_used = 1'b1;
        #1;
        chk("raw_stall", 32'(stall), 32'd1);
        tick();
        chk("raw_stall2", 32'(stall), 32'd1);
        wr_en   = 1'b1;
        wr_addr = 5'd8;
        wr_data = 32'hCAFE0008;
        #1;
        chk("raw_wb_stall", 32'(stall), BYP ? 32'd0 : 32'd1);
        if (BYP)
            chk("raw_fwd", rs_data, 32'hCAFE0008);
        tick();
        wr_en = 1'b0;
        #1;
        chk("raw_after", 32'(stall), 32'd0);
        chk("raw_cnt0", 32'(pend_cnt), 32'd0);
        chk("raw_data", rs_data, 32'hCAFE0008);
        idle();
        tick();

        // Writeback and re-issue to r8 in one cycle.
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        iss_dst   = 5'd8;
        tick();
        chk("same_pre", 32'(pend_cnt), 32'd1);
        wr_en   = 1'b1;
        wr_addr = 5'd8;
        wr_data = 32'h88;
        #1;
        chk("same_stall", 32'(stall), BYP ? 32'd0 : 32'd1);
        tick();
        idle();
        #1;
        chk("same_cnt", 32'(pend_cnt), BYP ? 32'd1 : 32'd0);
        tick();

        // Three more pending, then reset mid-stream.
        iss_valid = 1'b1;
        iss_wr    = 1'b1;
        for (int r = 10; r < 13; r++) begin
            iss_dst = 5'(r);
            tick();
        end
        chk("three_cnt", 32'(pend_cnt), BYP ? 32'd4 : 32'd3);
        iss_wr  = 1'b0;
        rs_used = 1'b1;
        rs_addr = 5'd11;
        #1;
        chk("three_stall", 32'(stall), 32'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_cnt", 32'(pend_cnt), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        all_zero("mid_rst_read");
        idle();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rs_addr   = raddr();
            rt_addr   = raddr();
            wr_addr   = raddr();
            iss_dst   = raddr();
            wr_data   = $urandom();
            wr_en     = ($urandom_range(0, 2) == 0);
            iss_valid = ($urandom_range(0, 3) != 0);
            iss_wr    = ($urandom_range(0, 3) != 0);
            rs_used   = ($urandom_range(0, 1) == 1);
            rt_used   = ($urandom_range(0, 1) == 1);
            if (n == 1500) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                compare();
                @(negedge clk);
                reset = 1'b0;
                @(posedge clk);
                #1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
